// File: rtl/controlador_ula.sv
// Arbiter/sequencer for a shared 4-bit ALU: two requesters, round-robin grant, operands held
// on the ALU for EXEC_CYCLES cycles, then the result is registered and a one-cycle gnt pulses.
module controlador_ula #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] res,
    output logic       res_cout,
    output logic       res_ov,
    output logic       res_zero,
    output logic       busy,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_y,
    input  logic       alu_cout,
    input  logic       alu_ov
);

    localparam logic [3:0] ExecLoad = 4'(EXEC_CYCLES);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       owner_q, owner_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [1:0] alu_sel_q, alu_sel_d;
    logic [3:0] res_q, res_d;
    logic       res_cout_q, res_cout_d;
    logic       res_ov_q, res_ov_d;
    logic       res_zero_q, res_zero_d;
    logic       pick1;
    logic       arith;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        res_d      = res_q;
        res_cout_d = res_cout_q;
        res_ov_d   = res_ov_q;
        res_zero_d = res_zero_q;
        // Requester 1 wins when alone, or when both ask and the pointer favours it.
        pick1      = req1 & (~req0 | ptr_q);
        // add/sub have alu_sel[1] clear; logic ops carry no meaningful flags.
        arith      = ~alu_sel_q[1];

        case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    owner_d   = pick1;
                    alu_sel_d = pick1 ? op1 : op0;
                    alu_a_d   = pick1 ? a1 : a0;
                    alu_b_d   = pick1 ? b1 : b0;
                    cnt_d     = ExecLoad;
                    state_d   = StExec;
                end
            end
            StExec: begin
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d      = 4'd0;
                    res_d      = alu_y;
                    res_cout_d = arith & alu_cout;
                    res_ov_d   = arith & alu_ov;
                    res_zero_d = (alu_y == 4'd0);
                    state_d    = StDone;
                end
            end
            StDone: begin
                ptr_d   = ~owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            cnt_q      <= 4'd0;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_sel_q  <= 2'd0;
            res_q      <= 4'd0;
            res_cout_q <= 1'b0;
            res_ov_q   <= 1'b0;
            res_zero_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            res_q      <= res_d;
            res_cout_q <= res_cout_d;
            res_ov_q   <= res_ov_d;
            res_zero_q <= res_zero_d;
        end
    end

    assign gnt0     = (state_q == StDone) & ~owner_q;
    assign gnt1     = (state_q == StDone) & owner_q;
    assign busy     = (state_q != StIdle);
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign res      = res_q;
    assign res_cout = res_cout_q;
    assign res_ov   = res_ov_q;
    assign res_zero = res_zero_q;

endmodule
